mem_arbiter: RTL

- Shares the single-port data DRAM among three requesters: 0 = host program/data loader, 1 = control-unit data path (load/store), 2 = instruction fetch.
- Round-robin arbitration, one transaction in flight at a time.
- Registered request/grant/done handshake; the DRAM has a fixed, parameterised read latency.
- Sits between the control FSM/fetch logic and the DRAM macro.

---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port DRAM among loader, load/store unit and fetch.
// One transaction in flight; all outputs registered; fixed read latency RD_LAT.
module mem_arbiter #(
    parameter int unsigned AW     = 12,
    parameter int unsigned DW     = 12,
    parameter int unsigned RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      req,
    input  logic [2:0]      we,
    input  logic [3*AW-1:0] addr,
    input  logic [3*DW-1:0] wdata,
    output logic [2:0]      gnt,
    output logic [2:0]      done,
    output logic [DW-1:0]   rdata,
    output logic            busy,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e          state_q, state_d;
    logic [1:0]      rr_last_q, rr_last_d;
    logic [1:0]      port_q, port_d;
    logic [2:0]      rd_cnt_q, rd_cnt_d;
    logic [2:0]      gnt_q, gnt_d;
    logic [2:0]      done_q, done_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            busy_q, busy_d;
    logic            mem_en_q, mem_en_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

    logic            win_vld;
    logic [1:0]      win_idx;
    logic [1:0]      cand;
    int unsigned     cand_i;

    // Search starts just after the last winner and wraps modulo 3.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        cand    = 2'd0;
        cand_i  = 0;
        for (int unsigned k = 1; k <= 3; k++) begin
            cand_i = (32'(rr_last_q) + k) % 3;
            cand   = cand_i[1:0];
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        port_d      = port_q;
        rd_cnt_d    = rd_cnt_q;
        gnt_d       = 3'b000;
        done_d      = 3'b000;
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (win_vld) begin
                    state_d        = StIssue;
                    gnt_d[win_idx] = 1'b1;
                    busy_d         = 1'b1;
                    mem_en_d       = 1'b1;
                    mem_we_d       = we[win_idx];
                    mem_addr_d     = addr[32'(win_idx)*AW +: AW];
                    mem_wdata_d    = wdata[32'(win_idx)*DW +: DW];
                    rr_last_d      = win_idx;
                    port_d         = win_idx;
                end else begin
                    state_d  = StIdle;
                    busy_d   = 1'b0;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                end
            end
            StIssue: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                if (mem_we_q) begin
                    state_d        = StDone;
                    done_d[port_q] = 1'b1;
                end else begin
                    // Counts the edges until the DRAM has had RD_LAT edges to produce data.
                    state_d  = StWait;
                    rd_cnt_d = 3'(RD_LAT);
                end
            end
            StWait: begin
                if (rd_cnt_q == 3'd1) begin
                    rdata_d        = mem_rdata;
                    done_d[port_q] = 1'b1;
                    rd_cnt_d       = 3'd0;
                    state_d        = StDone;
                end else begin
                    rd_cnt_d = rd_cnt_q - 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_last_q   <= 2'd2;
            port_q      <= 2'd0;
            rd_cnt_q    <= 3'd0;
            gnt_q       <= 3'b000;
            done_q      <= 3'b000;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            port_q      <= port_d;
            rd_cnt_q    <= rd_cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
